pipe_reg_rv: RTL and testbench

- Parametrised multi-stage pipeline register with a valid/ready handshake, an asynchronous reset and a synchronous flush.
- Generalises the single enable-gated flip-flop to DEPTH stages of DWIDTH data, each with its own valid bit.
- Bubbles collapse: a stage loads whenever it is empty or its contents are moving downstream.
- Used to retime long datapaths between producer and consumer blocks without losing throughput under backpressure.

---
 rtl/pipe_reg_rv.sv | 89 ++++++++
 tb/tb_pipe_reg_rv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_rv.sv
// Multi-stage valid/ready pipeline register with bubble collapse.
// Asynchronous reset, synchronous flush, and a registered count of occupied stages.
`timescale 1ns/1ps
module pipe_reg_rv #(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 3,
    parameter int POR_VALUE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DWIDTH-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DWIDTH-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [DWIDTH-1:0] POR_D = DWIDTH'(POR_VALUE);

    logic [DEPTH-1:0]  v_reg;
    logic [DEPTH-1:0]  v_next;
    logic [DEPTH-1:0]  vin;
    logic [DEPTH-1:0]  r;
    logic [DWIDTH-1:0] d_reg [DEPTH];
    logic [DWIDTH-1:0] din   [DEPTH];
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // Stage can load if downstream moves or any stage from here to the output is empty;
            // written flat rather than as a chain to keep the ready path free of bit-level loops.
            assign r[gi] = out_ready || !(&v_reg[DEPTH-1:gi]);

            if (gi == 0) begin : g_head
                assign vin[gi] = in_valid;
                assign din[gi] = in_data;
            end else begin : g_body
                assign vin[gi] = v_reg[gi-1];
                assign din[gi] = d_reg[gi-1];
            end

            assign v_next[gi] = r[gi] ? vin[gi] : v_reg[gi];
        end
    endgenerate

    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(v_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg     <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= POR_D;
            end
        end else if (flush) begin
            v_reg     <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= POR_D;
            end
        end else begin
            v_reg     <= v_next;
            count_reg <= count_next;
            // Empty slots only clear the valid bit; data is kept so in_data is never sampled when invalid.
            for (int i = 0; i < DEPTH; i++) begin
                if (r[i] && vin[i]) begin
                    d_reg[i] <= din[i];
                end
            end
        end
    end

    assign in_ready  = r[0] && !flush;
    assign out_data  = d_reg[DEPTH-1];
    assign out_valid = v_reg[DEPTH-1];
    assign count     = count_reg;

endmodule

// File: tb/tb_pipe_reg_rv.sv
// Directed bench for pipe_reg_rv (DWIDTH=8, DEPTH=3, POR_VALUE=A5).
`timescale 1ns/1ps
module tb_pipe_reg_rv;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_reg_rv #(
        .DWIDTH   (8),
        .DEPTH    (3),
        .POR_VALUE(32'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  idx;
        int  n;
        int  lo;
        int  hi;
        int  exp_cnt;
        logic acc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #2;
        check_eq("rst out_valid", out_valid, 0);
        check_eq("rst out_data", out_data, 8'hA5);
        check_eq("rst count", count, 0);
        step();
        rst = 1'b0;
        #1;
        check_eq("rel in_ready", in_ready, 1);

        // Mid-operation asynchronous reset with the pipeline full
        in_valid = 1'b1; in_data = 8'h77; step();
        in_data = 8'h78; step();
        in_data = 8'h79; step();
        in_valid = 1'b0;
        #1;
        check_eq("pre-rst count", count, 3);
        check_eq("pre-rst out_data", out_data, 8'h77);
        #2 rst = 1'b1;
        #1;
        check_eq("async rst out_valid", out_valid, 0);
        check_eq("async rst out_data", out_data, 8'hA5);
        check_eq("async rst count", count, 0);
        step();
        rst = 1'b0;
        #1;
        check_eq("post-rst in_ready", in_ready, 1);
        step();

        // Streaming 01..06 with out_ready held high
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 6);
            in_data  = 8'(c + 1);
            #1;
            lo = (c - 3 > 0) ? c - 3 : 0;
            hi = (c - 1 < 5) ? c - 1 : 5;
            exp_cnt = (hi >= lo) ? hi - lo + 1 : 0;
            check_eq($sformatf("stream c%0d count", c), count, exp_cnt);
            check_eq($sformatf("stream c%0d out_valid", c), out_valid, (c >= 3 && c <= 8) ? 1 : 0);
            if (c >= 3 && c <= 8)
                check_eq($sformatf("stream c%0d out_data", c), out_data, c - 2);
            if (c < 6)
                check_eq($sformatf("stream c%0d in_ready", c), in_ready, 1);
            step();
        end
        #1;
        check_eq("stream hold last data", out_data, 8'h06);

        // Backpressure: fill, stall, then drain in order
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + idx);
            #1;
            check_eq($sformatf("bp fill c%0d count", c), count, (c < 3) ? c : 3);
            check_eq($sformatf("bp fill c%0d in_ready", c), in_ready, (c < 3) ? 1 : 0);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        check_eq("bp stalled out_data", out_data, 8'h10);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 4);
            in_data  = 8'(8'h10 + idx);
            #1;
            if (out_valid) begin
                check_eq($sformatf("bp out #%0d", n), out_data, 8'h10 + n);
                n++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check_eq("bp delivered", n, 4);
        check_eq("bp accepted", idx, 4);

        // Bubble collapse: 20, idle, 21, idle with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h20; step();
        in_valid = 1'b0; in_data = 8'hEE; step();
        in_valid = 1'b1; in_data = 8'h21; step();
        in_valid = 1'b0; in_data = 8'hEE; step();
        #1;
        check_eq("bubble count", count, 2);
        check_eq("bubble out_valid", out_valid, 1);
        check_eq("bubble out_data", out_data, 8'h20);
        out_ready = 1'b1;
        step();
        check_eq("bubble second out_valid", out_valid, 1);
        check_eq("bubble second out_data", out_data, 8'h21);
        step();
        check_eq("bubble drained", out_valid, 0);
        check_eq("bubble drained count", count, 0);

        // Full pipeline with simultaneous push and pop
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h30; step();
        in_data = 8'h31; step();
        in_data = 8'h32; step();
        in_valid = 1'b0;
        #1;
        check_eq("full count", count, 3);
        check_eq("full in_ready", in_ready, 0);
        check_eq("full out_data", out_data, 8'h30);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        #1;
        check_eq("full+pop in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("push/pop count", count, 3);
        check_eq("push/pop out_data", out_data, 8'h31);
        step();
        check_eq("drain out_data 32", out_data, 8'h32);
        step();
        check_eq("drain out_data 33", out_data, 8'h33);
        step();
        check_eq("drain empty", out_valid, 0);

        // Flush with two items held and a concurrent push of 40
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h50; step();
        in_data = 8'h51; step();
        #1;
        check_eq("preflush count", count, 2);
        flush = 1'b1; in_data = 8'h40;
        #1;
        check_eq("flush in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("flush count", count, 0);
        check_eq("flush out_valid", out_valid, 0);
        check_eq("flush out_data", out_data, 8'hA5);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_valid) n++;
        end
        check_eq("flush nothing emerges", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
